// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared constants and types for the ID-stage hazard scoreboard.
package hazard_scoreboard_unit_pkg;

    localparam logic [6:0] J_TYPE    = 7'b1101111;
    localparam logic [6:0] JALR_TYPE = 7'b1100111;

    localparam int SB_MAX_LAT = 7;
    localparam int LAT_W      = $clog2(SB_MAX_LAT + 1);
    localparam int REG_SLOTS  = 32;

    typedef logic [LAT_W-1:0] lat_t;

    typedef enum logic [1:0] {
        PROD_ALU,
        PROD_LOAD,
        PROD_MUL
    } prod_class_e;

    function automatic prod_class_e classify(input logic is_load, input logic is_mul);
        if (is_load) return PROD_LOAD;
        if (is_mul)  return PROD_MUL;
        return PROD_ALU;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_sb_array.sv
// Per-register countdown counters: set on issue, decrement otherwise, frozen by hold_i.
module hazard_sb_array
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold_i,
    input  logic       set_en_i,
    input  logic [4:0] set_idx_i,
    input  lat_t       set_val_i,
    input  logic [4:0] rd_a_idx_i,
    input  logic [4:0] rd_b_idx_i,
    output lat_t       rd_a_cnt_o,
    output lat_t       rd_b_cnt_o,
    output logic       any_busy_o
);

    lat_t                 cnt_all [REG_SLOTS];
    logic [REG_SLOTS-1:0] busy_vec;

    genvar gi;
    generate
        for (gi = 0; gi < REG_SLOTS; gi++) begin : g_entry
            if (gi == 0 || gi >= NUM_REGS) begin : g_untracked
                // x0 and slots beyond NUM_REGS never hold a pending write.
                assign cnt_all[gi] = '0;
            end else begin : g_tracked
                lat_t cnt_q;
                lat_t cnt_d;

                always_comb begin
                    cnt_d = cnt_q;
                    if (!hold_i) begin
                        if (set_en_i && set_idx_i == 5'(gi)) begin
                            cnt_d = set_val_i;
                        end else if (cnt_q != '0) begin
                            cnt_d = cnt_q - lat_t'(1);
                        end
                    end
                end

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                assign cnt_all[gi] = cnt_q;
            end
            assign busy_vec[gi] = (cnt_all[gi] != '0);
        end
    endgenerate

    assign rd_a_cnt_o = cnt_all[rd_a_idx_i];
    assign rd_b_cnt_o = cnt_all[rd_b_idx_i];
    assign any_busy_o = |busy_vec;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit: scoreboard-driven stalls, branch/jump flushes, memory freeze.
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int LOAD_LAT = 2,
    parameter int MUL_LAT  = 3,
    parameter int MAX_LAT  = SB_MAX_LAT,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [6:0]        id_opcode,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              id_is_mul,
    input  logic              ex_branch_taken,
    input  logic              mem_busy,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              flush_if,
    output logic              flush_id,
    output logic              sb_busy,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam lat_t LOAD_SET = lat_t'((LOAD_LAT > MAX_LAT) ? MAX_LAT : LOAD_LAT);
    localparam lat_t MUL_SET  = lat_t'((MUL_LAT  > MAX_LAT) ? MAX_LAT : MUL_LAT);

    lat_t        rs1_cnt;
    lat_t        rs2_cnt;
    logic        any_busy;
    logic        hazard;
    logic        issue;
    logic        set_en;
    lat_t        set_val;
    prod_class_e prod_class;

    logic [PERF_W-1:0] stall_cycles_q;
    logic [PERF_W-1:0] stall_cycles_d;

    assign hazard = id_valid && ((id_uses_rs1 && rs1_cnt != '0) ||
                                 (id_uses_rs2 && rs2_cnt != '0));
    assign issue  = rst_n && id_valid && !mem_busy && !ex_branch_taken && !hazard;
    assign set_en = issue && id_reg_write && (id_rd != 5'd0);

    assign prod_class = classify(id_is_load, id_is_mul);

    always_comb begin
        set_val = '0;
        case (prod_class)
            PROD_LOAD: set_val = LOAD_SET;
            PROD_MUL:  set_val = MUL_SET;
            default:   set_val = '0;
        endcase
    end

    hazard_sb_array #(
        .NUM_REGS (NUM_REGS)
    ) u_sb_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold_i     (mem_busy),
        .set_en_i   (set_en),
        .set_idx_i  (id_rd),
        .set_val_i  (set_val),
        .rd_a_idx_i (id_rs1),
        .rd_b_idx_i (id_rs2),
        .rd_a_cnt_o (rs1_cnt),
        .rd_b_cnt_o (rs2_cnt),
        .any_busy_o (any_busy)
    );

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        flush_if  = 1'b0;
        flush_id  = 1'b0;
        sb_busy   = 1'b0;
        if (rst_n) begin
            sb_busy = any_busy;
            if (mem_busy) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
            end else if (ex_branch_taken) begin
                // The ID instruction is squashed, so any hazard it has is moot.
                flush_if = 1'b1;
                flush_id = 1'b1;
            end else if (id_valid && id_opcode == J_TYPE) begin
                flush_if = 1'b1;
            end else if (id_opcode == JALR_TYPE && !hazard) begin
                flush_if = 1'b1;
            end else if (hazard) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_id && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Table-driven bench: each row is one cycle of ID/EX/MEM inputs plus expected hazard outputs.
module tb_hazard_scoreboard_unit;

    localparam logic [6:0] OP_ALU  = 7'b0110011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_J    = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic        clk = 1'b0;
    logic        rst_n, id_valid, id_uses_rs1, id_uses_rs2, id_reg_write;
    logic        id_is_load, id_is_mul, ex_branch_taken, mem_busy;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        stall_if, stall_id, bubble_ex, flush_if, flush_id, sb_busy;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_scoreboard_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_opcode       (id_opcode),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_is_load      (id_is_load),
        .id_is_mul       (id_is_mul),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .bubble_ex       (bubble_ex),
        .flush_if        (flush_if),
        .flush_id        (flush_id),
        .sb_busy         (sb_busy),
        .stall_cycles    (stall_cycles)
    );

    // exp bit order: {stall_if, stall_id, bubble_ex, flush_if, flush_id, sb_busy}
    typedef struct {
        logic       rst;
        logic       valid;
        logic [6:0] op;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       mul;
        logic       br;
        logic       busy;
        logic [5:0] exp;
    } vec_t;

    typedef struct {
        logic [5:0]  outs;
        logic [31:0] perf;
        bit          perf_chk;
    } exp_t;

    vec_t vecs[$];
    exp_t expq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic row(input logic r, input logic v, input logic [6:0] op,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic rw,
                       input logic ld, input logic mul,
                       input logic br, input logic busy, input logic [5:0] e);
        vec_t x;
        x.rst = r; x.valid = v; x.op = op; x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2;
        x.rd = rd; x.rw = rw; x.ld = ld; x.mul = mul; x.br = br; x.busy = busy; x.exp = e;
        vecs.push_back(x);
    endtask

    // Producer / consumer shorthands (rst=1, no branch, no freeze).
    task automatic load(input logic [4:0] rd, input logic [5:0] e);
        row(1, 1, OP_LD, 5'd1, 1, 5'd0, 0, rd, 1, 1, 0, 0, 0, e);
    endtask
    task automatic mul(input logic [4:0] rd, input logic [5:0] e);
        row(1, 1, OP_ALU, 5'd1, 1, 5'd2, 1, rd, 1, 0, 1, 0, 0, e);
    endtask
    task automatic alu(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [5:0] e);
        row(1, 1, OP_ALU, rs1, 1, rs2, 1, rd, 1, 0, 0, 0, 0, e);
    endtask

    initial begin
        int   perf_model = 0;
        bit   perf_known = 0;
        exp_t ex;
        exp_t got;

        // Reset with live inputs and a freeze request: everything forced low.
        row(0, 1, OP_LD, 5'd5, 1, 5'd6, 1, 5'd5, 1, 1, 0, 1, 1, 6'b000000);
        row(0, 0, OP_ALU, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 6'b000000);
        // Load-use: two stall cycles then issue.
        load(5'd5,                 6'b000000);
        alu(5'd5, 5'd0, 5'd6,      6'b111001);
        alu(5'd5, 5'd0, 5'd6,      6'b111001);
        alu(5'd5, 5'd0, 5'd6,      6'b000000);
        // MUL, two independent ops, consumer on rs2: one stall cycle left.
        mul(5'd7,                  6'b000000);
        alu(5'd1, 5'd2, 5'd8,      6'b000001);
        alu(5'd2, 5'd3, 5'd8,      6'b000001);
        alu(5'd0, 5'd7, 5'd10,     6'b111001);
        alu(5'd0, 5'd7, 5'd10,     6'b000000);
        // Memory freeze over a load-use hazard: counters frozen, then two stalls.
        load(5'd5,                 6'b000000);
        for (int i = 0; i < 4; i++)
            row(1, 1, OP_ALU, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, 1, 6'b110001);
        alu(5'd5, 5'd0, 5'd6,      6'b111001);
        alu(5'd5, 5'd0, 5'd6,      6'b111001);
        alu(5'd5, 5'd0, 5'd6,      6'b000000);
        // Branch over a hazard: flush, scoreboard keeps counting down.
        load(5'd5,                 6'b000000);
        row(1, 1, OP_ALU, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 1, 0, 6'b000111);
        alu(5'd5, 5'd0, 5'd6,      6'b111001);
        alu(5'd5, 5'd0, 5'd6,      6'b000000);
        // A load squashed by a branch never enters the scoreboard.
        row(1, 1, OP_LD, 5'd1, 1, 5'd0, 0, 5'd10, 1, 1, 0, 1, 0, 6'b000110);
        alu(5'd10, 5'd10, 5'd11,   6'b000000);
        // WAW: ALU write after MUL clears the entry.
        mul(5'd9,                  6'b000000);
        alu(5'd1, 5'd0, 5'd9,      6'b000001);
        alu(5'd9, 5'd9, 5'd12,     6'b000000);
        // JAL flushes IF only; frozen JAL just stalls.
        row(1, 1, OP_J, 5'd0, 0, 5'd0, 0, 5'd1, 1, 0, 0, 0, 0, 6'b000100);
        row(1, 1, OP_J, 5'd0, 0, 5'd0, 0, 5'd1, 1, 0, 0, 0, 1, 6'b110000);
        // JALR waits out its hazard before redirecting.
        load(5'd11,                6'b000000);
        row(1, 1, OP_JALR, 5'd11, 1, 5'd0, 0, 5'd1, 1, 0, 0, 0, 0, 6'b111001);
        row(1, 1, OP_JALR, 5'd11, 1, 5'd0, 0, 5'd1, 1, 0, 0, 0, 0, 6'b111001);
        row(1, 1, OP_JALR, 5'd11, 1, 5'd0, 0, 5'd1, 1, 0, 0, 0, 0, 6'b000100);
        // Load to x0 is never tracked.
        load(5'd0,                 6'b000000);
        alu(5'd0, 5'd0, 5'd3,      6'b000000);
        // Unread source does not stall even when its register is pending.
        load(5'd12,                6'b000000);
        row(1, 1, OP_ALU, 5'd12, 0, 5'd12, 0, 5'd13, 1, 0, 0, 0, 0, 6'b000001);
        alu(5'd12, 5'd0, 5'd13,    6'b111001);
        alu(5'd12, 5'd0, 5'd13,    6'b000000);
        // Reset in the middle of a stall clears outputs and scoreboard.
        load(5'd5,                 6'b000000);
        alu(5'd5, 5'd0, 5'd6,      6'b111001);
        row(0, 1, OP_ALU, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, 0, 6'b000000);
        alu(5'd5, 5'd0, 5'd6,      6'b000000);
        row(1, 0, OP_ALU, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 6'b000000);

        foreach (vecs[i]) begin
            rst_n           = vecs[i].rst;
            id_valid        = vecs[i].valid;
            id_opcode       = vecs[i].op;
            id_rs1          = vecs[i].rs1;
            id_uses_rs1     = vecs[i].u1;
            id_rs2          = vecs[i].rs2;
            id_uses_rs2     = vecs[i].u2;
            id_rd           = vecs[i].rd;
            id_reg_write    = vecs[i].rw;
            id_is_load      = vecs[i].ld;
            id_is_mul       = vecs[i].mul;
            ex_branch_taken = vecs[i].br;
            mem_busy        = vecs[i].busy;

            ex.outs     = vecs[i].exp;
            ex.perf     = perf_model;
            ex.perf_chk = perf_known;
            expq.push_back(ex);

            if (!vecs[i].rst) begin
                perf_model = 0;
                perf_known = 1;
            end else begin
                perf_model = perf_model + int'(vecs[i].exp[4]);
            end

            @(negedge clk);
            got = expq.pop_front();
            n_checks++;
            if ({stall_if, stall_id, bubble_ex, flush_if, flush_id, sb_busy} === got.outs) begin
                n_pass++;
            end else begin
                $display("FAIL row%0d outs {sif,sid,bub,fif,fid,sbb} got %b want %b", i,
                         {stall_if, stall_id, bubble_ex, flush_if, flush_id, sb_busy}, got.outs);
            end
            if (got.perf_chk) begin
                n_checks++;
                if (stall_cycles === got.perf) n_pass++;
                else $display("FAIL row%0d stall_cycles got %0d want %0d", i, stall_cycles, got.perf);
            end
            $display("row%0d rst=%b op=%b rs1=%0d rs2=%0d rd=%0d br=%b busy=%b -> outs=%b perf=%0d",
                     i, vecs[i].rst, vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                     vecs[i].br, vecs[i].busy,
                     {stall_if, stall_id, bubble_ex, flush_if, flush_id, sb_busy}, stall_cycles);
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
